// File: rtl/i2c_gain_master.sv
// I2C burst-write master: START, address, register byte, up to MAX_BURST data bytes, STOP.
// Define I2C_MASTER_RETRY_EN to retry an address NACK up to two times before flagging ack_error.
module i2c_gain_master #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h6A,
    parameter int unsigned QTR_DIV    = 5,
    parameter int unsigned MAX_BURST  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] start_addr,
    input  logic [3:0] byte_count,
    output logic [3:0] data_idx,
    output logic       data_req,
    input  logic [7:0] wr_data,
    output logic       scl,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAckA, StReg, StAckR, StData, StAckD, StStop
    } state_t;

    localparam logic [7:0] QtrLast  = 8'(QTR_DIV - 1);
    localparam logic [7:0] QtrPre   = 8'(QTR_DIV - 2);
    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_t     state;
    logic [7:0] qtr_cnt;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] reg_addr;
    logic [3:0] n_bytes;
    logic       ack_nack;
`ifdef I2C_MASTER_RETRY_EN
    logic [1:0] retry_cnt;
    logic       restart;
`endif

    logic qtr_end, qtr_pre, more_data;
    assign qtr_end   = (qtr_cnt == QtrLast);
    assign qtr_pre   = (qtr_cnt == QtrPre);
    assign more_data = (data_idx < n_bytes);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            qtr_cnt   <= 8'd0;
            phase     <= 2'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            reg_addr  <= 8'd0;
            n_bytes   <= 4'd0;
            ack_nack  <= 1'b0;
            scl       <= 1'b1;
            sda_o     <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_req  <= 1'b0;
            ack_error <= 1'b0;
            data_idx  <= 4'd0;
`ifdef I2C_MASTER_RETRY_EN
            retry_cnt <= 2'd0;
            restart   <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            data_req <= 1'b0;
            if (state != StIdle) qtr_cnt <= qtr_end ? 8'd0 : qtr_cnt + 8'd1;

            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StStart;
                        qtr_cnt   <= 8'd0;
                        phase     <= 2'd0;
                        reg_addr  <= start_addr;
                        n_bytes   <= (byte_count > MaxBurst) ? MaxBurst : byte_count;
                        data_idx  <= 4'd0;
                        scl       <= 1'b1;
                        sda_o     <= 1'b1;
                        sda_oe    <= 1'b1;
                        busy      <= 1'b1;
                        ack_error <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
                        retry_cnt <= 2'd0;
                        restart   <= 1'b0;
`endif
                    end
                end

                StStart: begin
                    if (qtr_end) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd0) begin
                            sda_o <= 1'b0;
                        end else if (phase == 2'd1) begin
                            scl <= 1'b0;
                        end else begin
                            state   <= StAddr;
                            shreg   <= {SLAVE_ADDR, 1'b0};
                            sda_o   <= SLAVE_ADDR[6];
                            bit_cnt <= 3'd0;
                            phase   <= 2'd0;
                        end
                    end
                end

                StAddr, StReg, StData: begin
                    if (qtr_end) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd1) begin
                            scl <= 1'b1;
                        end else if (phase == 2'd3) begin
                            scl <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= (state == StAddr) ? StAckA :
                                          (state == StReg)  ? StAckR : StAckD;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_o   <= shreg[6];
                            end
                        end
                    end
                end

                StAckA, StAckR, StAckD: begin
                    // Fetch the next data byte one cycle before the ACK bit ends.
                    if (state != StAckA && phase == 2'd3 && qtr_pre && !ack_nack && more_data)
                        data_req <= 1'b1;
                    if (qtr_end) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd1) begin
                            scl <= 1'b1;
                        end else if (phase == 2'd2) begin
                            ack_nack <= sda_i;
                        end else if (phase == 2'd3) begin
                            scl     <= 1'b0;
                            sda_oe  <= 1'b1;
                            bit_cnt <= 3'd0;
                            if (ack_nack) begin
                                state <= StStop;
                                sda_o <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
                                if (state == StAckA && retry_cnt != 2'd2) begin
                                    retry_cnt <= retry_cnt + 2'd1;
                                    restart   <= 1'b1;
                                end else begin
                                    ack_error <= 1'b1;
                                end
`else
                                ack_error <= 1'b1;
`endif
                            end else if (state == StAckA) begin
                                state <= StReg;
                                shreg <= reg_addr;
                                sda_o <= reg_addr[7];
                            end else if (more_data) begin
                                state    <= StData;
                                shreg    <= wr_data;
                                sda_o    <= wr_data[7];
                                data_idx <= data_idx + 4'd1;
                            end else begin
                                state <= StStop;
                                sda_o <= 1'b0;
                            end
                        end
                    end
                end

                StStop: begin
                    if (qtr_end) begin
                        phase <= phase + 2'd1;
                        if (phase == 2'd0) begin
                            scl <= 1'b1;
                        end else if (phase == 2'd1) begin
                            sda_o <= 1'b1;
                        end else begin
`ifdef I2C_MASTER_RETRY_EN
                            if (restart) begin
                                restart <= 1'b0;
                                state   <= StStart;
                                phase   <= 2'd0;
                            end else begin
`else
                            begin
`endif
                                state  <= StIdle;
                                phase  <= 2'd0;
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/i2c_gain_master.md
I2C_GAIN_MASTER -- requirements
Module: i2c_gain_master

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h6A, the 7-bit target address sent in every transaction.
REQ-002 SHALL have parameter QTR_DIV, default 5, the number of clk cycles per SCL quarter-period; legal range 2..255.
REQ-003 SHALL have parameter MAX_BURST, default 10, the maximum number of data bytes per transaction.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin a burst write.
REQ-007 SHALL have port start_addr, input, 8 bits: the register address byte, sampled when start is accepted.
REQ-008 SHALL have port byte_count, input, 4 bits: the number of data bytes, sampled when start is accepted.
REQ-009 SHALL have port data_idx, output, 4 bits: the index (0-based) of the next data byte required.
REQ-010 SHALL have port data_req, output, 1 bit: a one-cycle pulse; wr_data is sampled in the same cycle.
REQ-011 SHALL have port wr_data, input, 8 bits: the data byte for data_idx.
REQ-012 SHALL have port scl, output, 1 bit: the I2C clock line.
REQ-013 SHALL have ports sda_o (output, 1 bit, SDA drive value), sda_oe (output, 1 bit, SDA drive enable) and sda_i (input, 1 bit, sampled SDA).
REQ-014 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse at end of STOP) and ack_error (output, 1, sticky).

Function
REQ-015 SHALL run the FSM states IDLE, START, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, STOP in that order; DATA and ACK_D repeat once per byte.
REQ-016 SHALL, in IDLE with start=1, latch its inputs, clear ack_error, set busy and enter START on the next edge.
REQ-017 SHALL clamp byte_count above MAX_BURST to MAX_BURST; byte_count=0 SHALL go from ACK_R directly to STOP.
REQ-018 SHALL generate START as three quarters: SDA=1/SCL=1, then SDA=0/SCL=1, then SDA=0/SCL=0.
REQ-019 SHALL make each bit four quarters: Q0 and Q1 with SCL=0, SDA updated at the start of Q0; Q2 and Q3 with SCL=1.
REQ-020 SHALL send bytes MSB first: ADDR={SLAVE_ADDR,1'b0}, then REG=start_addr, then DATA bytes.
REQ-021 SHALL hold sda_oe=0 during ACK bits and sample sda_i on the last cycle of Q2; 0 = ACK, 1 = NACK.
REQ-022 SHALL pulse data_req in the last cycle before each DATA state begins, with data_idx=k for byte k; data_idx SHALL increment after each data_req.
REQ-023 SHALL respond to any NACK by setting ack_error and going to STOP, sending no further bytes.
REQ-024 SHALL generate STOP as SDA=0/SCL=0, then SDA=0/SCL=1, then SDA=1/SCL=1, each one quarter long, then pulse done for one cycle, clear busy and return to IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL give a transaction a length of exactly (6 + 36*(2+N))*QTR_DIV clk cycles from START entry to done, where N is the clamped byte_count and there are no NACKs.

Reset
REQ-027 SHALL, on rst=1, set the FSM to IDLE and drive scl=1, sda_o=1, sda_oe=0, busy=0, done=0, data_req=0, ack_error=0 and data_idx=0.
REQ-028 SHALL abandon a transaction if rst is asserted mid-transaction, with the bus released on the next edge and no STOP generated.

Configuration
REQ-029 SHALL, when I2C_MASTER_RETRY_EN is defined, respond to a NACK in ACK_A by issuing STOP and then restarting from START, up to 2 retries; ack_error SHALL be set only when the final attempt is NACKed.
REQ-030 SHALL, when I2C_MASTER_RETRY_EN is undefined, abort immediately on an address NACK per REQ-023.

Verification
REQ-031 The bench SHALL run start with start_addr=8'h01, byte_count=10, wr_data=17+data_idx, and a slave model ACKing everything -> bytes D4,01,11..1A on the bus; done after 438*QTR_DIV cycles; ack_error=0.
REQ-032 The bench SHALL run byte_count=0 with start_addr=8'h07 -> only D4,07 sent, then STOP; no data_req pulse.
REQ-033 The bench SHALL run byte_count=15 -> clamped to 10, with exactly 10 data_req pulses and data_idx 0..9.
REQ-034 The bench SHALL have the slave NACK the 3rd data byte -> STOP follows immediately; ack_error=1; 3 data_req pulses.
REQ-035 The bench SHALL NACK the address with RETRY_EN defined -> 3 START/STOP pairs, then ack_error=1; with RETRY_EN undefined -> 1 pair, ack_error=1.
REQ-036 The bench SHALL assert rst during the 2nd data byte -> next edge scl=1, sda_oe=0, busy=0; a following start SHALL complete normally.
